cus19_regfile_mp: RTL and testbench
===================================

Name: cus19_regfile_mp

Overview:
- Parametrised successor to the CUS19 integer register file.
- Adds N combinational read ports, selectable single/pair write width, write-to-read forwarding on every port, and a per-register pending-write scoreboard.
- Sits between decode (reads, reservations) and writeback (writes) in the CUS19 core. Pair writes carry 2*Data_Width results (e.g. MUL) into two consecutive registers.

Parameters:
- Data_Width, 8: register width in bits.
- Reg_Addr_Width, 4: address width; depth = 2**Reg_Addr_Width.
- Num_Rd_Ports, 2: number of independent read ports, >=1.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- rd_addr_in  in  Num_Rd_Ports*Reg_Addr_Width  packed read addresses; port k in slice k.
- rd_data_out  out  Num_Rd_Ports*Data_Width  packed read data; port k in slice k.
- rd_busy_out  out  Num_Rd_Ports  port k's register has an outstanding reservation.
- wr_en_in  in  1  write strobe.
- wr_pair_in  in  1  0 = single write (low half only); 1 = pair write.
- wr_addr_in  in  Reg_Addr_Width  write base address.
- wr_data_in  in  2*Data_Width  low half to base, high half to base+1.
- rsv_en_in  in  1  reserve (mark pending) strobe.
- rsv_pair_in  in  1  reserve base only, or base and base+1.
- rsv_addr_in  in  Reg_Addr_Width  reservation base address.
- rsv_conflict_out  out  1  registered pulse: the last reservation hit an already-busy register.

Behaviour:
- Reset (asynchronous, rst_in=1): all registers = 0; all busy bits = 0; rsv_conflict_out = 0. Consequently rd_data_out = 0 and rd_busy_out = 0.
- Write:
  - On posedge with wr_en_in=1: reg[base] <= wr_data_in[DW-1:0].
  - If wr_pair_in=1, also reg[base+1] <= wr_data_in[2DW-1:DW].
- Wrap-around: base+1 is computed modulo depth. A pair write at the top address writes its high half to reg[0].
- Reads:
  - Combinational, zero latency.
  - Forwarding on port k: if wr_en_in=1 and rd_addr matches base, output the low half of wr_data_in. If wr_pair_in=1 and rd_addr matches base+1, output the high half. Otherwise output the stored register.
  - All ports forward independently and simultaneously.
- Scoreboard:
  - One busy bit per register.
  - A write clears the busy bits of the registers it writes, at posedge.
  - A reservation sets the busy bits of its target registers, at posedge.
  - Same register written and reserved in the same cycle: the set wins, and the bit stays 1 (a new producer is pending).
- rd_busy_out[k]: busy[rd_addr_k] AND NOT (same-cycle write to that address). A read satisfied by forwarding therefore reports not-busy.
- rsv_conflict_out:
  - Registered, high for exactly the one cycle after a reservation in which any target was busy and was not being cleared by a write that same cycle.
  - Otherwise 0.
  - The reservation is still applied on a conflict.
- Reservation wrap: a pair reservation at the top address wraps to reg[0], same as writes.
- Writing an unreserved register is legal; the busy bit stays 0.
- Reset mid-operation: state clears immediately; any write or reservation in progress is discarded.
- No hardwired-zero register: all addresses are writable.

Decomposition:
- Shared package cus19_rf_pkg:
  - default widths;
  - function next_addr(base) implementing the modulo-depth increment, reused by the write and reservation paths.
- One sub-module, cus19_rf_scoreboard: busy-bit array, set/clear priority, conflict pulse and per-port busy masking.
- Top level: storage, write decode and forwarding muxes generated per read port.

Test Plan:
1. Reset, then single write addr 3 data 16'h00AB → port0 @3 reads 8'hAB; reg 4 unchanged at 0; all rd_busy_out = 0.
2. Pair write addr 2 data 16'hABCD → reg2=CD, reg3=AB, read on ports 0/1 the next cycle. Pair write addr 15 data 16'h1234 → reg15=34, reg0=12 (wrap).
3. Forwarding: wr_en=1, pair, addr 5, data 16'h1122, with port0@5 and port1@6 in the same cycle → 22 and 11 before the edge; stored values match after the edge.
4. Scoreboard:
   - Reserve pair @7 → next cycle rd_busy on 7 and 8 = 1.
   - Single write @7 → busy7 = 0 that cycle (forwarded) and after; busy8 still 1.
   - Pair write @7 clears busy8.
5. Conflicts:
   - Reserve @9; re-reserve @9 the next cycle → rsv_conflict_out = 1 for one cycle, then 0.
   - Same-cycle write @9 and reserve @9 → no conflict; busy9 = 1 afterwards.
6. Assert rst_in mid-sequence with busy bits set and wr_en=1 → all regs, busy bits and rsv_conflict_out read 0 immediately; the pending write is not applied after release.

Source files
------------

// File: rtl/cus19_rf_pkg.sv
// Shared widths and address helpers for the CUS19 multi-port register file.
package cus19_rf_pkg;

    localparam int unsigned DefDataWidth    = 8;
    localparam int unsigned DefRegAddrWidth = 4;
    localparam int unsigned DefNumRdPorts   = 2;

    // Widest register address next_addr() can handle.
    localparam int unsigned MaxAddrWidth = 16;

    // Modulo-depth increment: the pair partner of the top register is register 0.
    function automatic logic [MaxAddrWidth-1:0] next_addr(
        input logic [MaxAddrWidth-1:0] base,
        input int unsigned             addr_width
    );
        logic [MaxAddrWidth-1:0] mask;
        mask = MaxAddrWidth'((32'd1 << addr_width) - 32'd1);
        return (base + MaxAddrWidth'(1)) & mask;
    endfunction

endpackage

// File: rtl/cus19_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reservations and
// cleared by writes, with a registered conflict pulse and per-port busy view.
module cus19_rf_scoreboard
    import cus19_rf_pkg::*;
#(
    parameter int unsigned Reg_Addr_Width = DefRegAddrWidth,
    parameter int unsigned Num_Rd_Ports   = DefNumRdPorts
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   wr_en_i,
    input  logic                                   wr_pair_i,
    input  logic [Reg_Addr_Width-1:0]              wr_addr_i,
    input  logic                                   rsv_en_i,
    input  logic                                   rsv_pair_i,
    input  logic [Reg_Addr_Width-1:0]              rsv_addr_i,
    input  logic [Num_Rd_Ports*Reg_Addr_Width-1:0] rd_addr_i,
    output logic [Num_Rd_Ports-1:0]                rd_busy_o,
    output logic                                   rsv_conflict_o
);

    localparam int unsigned Depth = 1 << Reg_Addr_Width;

    logic [Depth-1:0]          busy_q, busy_d;
    logic [Depth-1:0]          wr_mask, rsv_mask;
    logic [Reg_Addr_Width-1:0] wr_hi_addr, rsv_hi_addr;
    logic                      conflict_q, conflict_d;

    assign wr_hi_addr  = Reg_Addr_Width'(next_addr(MaxAddrWidth'(wr_addr_i), Reg_Addr_Width));
    assign rsv_hi_addr = Reg_Addr_Width'(next_addr(MaxAddrWidth'(rsv_addr_i), Reg_Addr_Width));

    // Decode the registers touched by this cycle's write and reservation.
    always_comb begin
        wr_mask  = '0;
        rsv_mask = '0;
        if (wr_en_i) begin
            wr_mask[wr_addr_i] = 1'b1;
            if (wr_pair_i) begin
                wr_mask[wr_hi_addr] = 1'b1;
            end
        end
        if (rsv_en_i) begin
            rsv_mask[rsv_addr_i] = 1'b1;
            if (rsv_pair_i) begin
                rsv_mask[rsv_hi_addr] = 1'b1;
            end
        end
    end

    // Set beats clear: a register both written and re-reserved has a new producer pending.
    // A conflict only counts a busy target that this cycle's write is not retiring.
    always_comb begin
        busy_d     = (busy_q & ~wr_mask) | rsv_mask;
        conflict_d = |(rsv_mask & busy_q & ~wr_mask);
    end

    // Busy array and conflict pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign rsv_conflict_o = conflict_q;

    // A read served by forwarding already has its value, so it is reported not-busy.
    always_comb begin
        rd_busy_o = '0;
        for (int k = 0; k < int'(Num_Rd_Ports); k++) begin
            rd_busy_o[k] = busy_q[rd_addr_i[k*Reg_Addr_Width +: Reg_Addr_Width]]
                         & ~wr_mask[rd_addr_i[k*Reg_Addr_Width +: Reg_Addr_Width]];
        end
    end

endmodule

// File: rtl/cus19_regfile_mp.sv
// CUS19 integer register file: N combinational read ports with write forwarding,
// single or pair writes, and a pending-write scoreboard.
module cus19_regfile_mp
    import cus19_rf_pkg::*;
#(
    parameter int unsigned Data_Width     = DefDataWidth,
    parameter int unsigned Reg_Addr_Width = DefRegAddrWidth,
    parameter int unsigned Num_Rd_Ports   = DefNumRdPorts
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic [Num_Rd_Ports*Reg_Addr_Width-1:0] rd_addr_in,
    output logic [Num_Rd_Ports*Data_Width-1:0]     rd_data_out,
    output logic [Num_Rd_Ports-1:0]                rd_busy_out,
    input  logic                                   wr_en_in,
    input  logic                                   wr_pair_in,
    input  logic [Reg_Addr_Width-1:0]              wr_addr_in,
    input  logic [2*Data_Width-1:0]                wr_data_in,
    input  logic                                   rsv_en_in,
    input  logic                                   rsv_pair_in,
    input  logic [Reg_Addr_Width-1:0]              rsv_addr_in,
    output logic                                   rsv_conflict_out
);

    localparam int unsigned Depth = 1 << Reg_Addr_Width;

    logic [Data_Width-1:0]     regs_q [Depth];
    logic [Reg_Addr_Width-1:0] wr_hi_addr;
    logic [Data_Width-1:0]     wr_lo_data, wr_hi_data;

    assign wr_hi_addr = Reg_Addr_Width'(next_addr(MaxAddrWidth'(wr_addr_in), Reg_Addr_Width));
    assign wr_lo_data = wr_data_in[Data_Width-1:0];
    assign wr_hi_data = wr_data_in[2*Data_Width-1:Data_Width];

    // Register storage; every address is writable, there is no hardwired zero.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(Depth); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_in) begin
            regs_q[wr_addr_in] <= wr_lo_data;
            if (wr_pair_in) begin
                regs_q[wr_hi_addr] <= wr_hi_data;
            end
        end
    end

    // Per-port read mux with same-cycle write forwarding.
    for (genvar k = 0; k < int'(Num_Rd_Ports); k++) begin : g_rd_port
        logic [Reg_Addr_Width-1:0] addr;
        logic [Data_Width-1:0]     data;

        assign addr = rd_addr_in[k*Reg_Addr_Width +: Reg_Addr_Width];

        // Forward the low half on a base hit, the high half on a pair partner hit.
        always_comb begin
            data = regs_q[addr];
            if (wr_en_in && (addr == wr_addr_in)) begin
                data = wr_lo_data;
            end else if (wr_en_in && wr_pair_in && (addr == wr_hi_addr)) begin
                data = wr_hi_data;
            end
        end

        assign rd_data_out[k*Data_Width +: Data_Width] = data;
    end

    cus19_rf_scoreboard #(
        .Reg_Addr_Width (Reg_Addr_Width),
        .Num_Rd_Ports   (Num_Rd_Ports)
    ) u_scoreboard (
        .clk_i          (clk_in),
        .rst_i          (rst_in),
        .wr_en_i        (wr_en_in),
        .wr_pair_i      (wr_pair_in),
        .wr_addr_i      (wr_addr_in),
        .rsv_en_i       (rsv_en_in),
        .rsv_pair_i     (rsv_pair_in),
        .rsv_addr_i     (rsv_addr_in),
        .rd_addr_i      (rd_addr_in),
        .rd_busy_o      (rd_busy_out),
        .rsv_conflict_o (rsv_conflict_out)
    );

endmodule

// File: tb/tb_cus19_regfile_mp.sv
// Directed bench for cus19_regfile_mp with default parameters (8-bit data, 16 regs, 2 ports).
module tb_cus19_regfile_mp;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  rd_addr_in;
    logic [15:0] rd_data_out;
    logic [1:0]  rd_busy_out;
    logic        wr_en_in;
    logic        wr_pair_in;
    logic [3:0]  wr_addr_in;
    logic [15:0] wr_data_in;
    logic        rsv_en_in;
    logic        rsv_pair_in;
    logic [3:0]  rsv_addr_in;
    logic        rsv_conflict_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cus19_regfile_mp dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rd_addr_in       (rd_addr_in),
        .rd_data_out      (rd_data_out),
        .rd_busy_out      (rd_busy_out),
        .wr_en_in         (wr_en_in),
        .wr_pair_in       (wr_pair_in),
        .wr_addr_in       (wr_addr_in),
        .wr_data_in       (wr_data_in),
        .rsv_en_in        (rsv_en_in),
        .rsv_pair_in      (rsv_pair_in),
        .rsv_addr_in      (rsv_addr_in),
        .rsv_conflict_out (rsv_conflict_out)
    );

    always #5 clk_in = ~clk_in;

    // Advance past the next rising edge, then settle.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Port 0 reads p0, port 1 reads p1, then settle.
    task automatic set_rd(input logic [3:0] p0, input logic [3:0] p1);
        rd_addr_in = {p1, p0};
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        rd_addr_in = 8'h10; wr_en_in = 0; wr_pair_in = 0; wr_addr_in = 0; wr_data_in = 0;
        rsv_en_in = 0; rsv_pair_in = 0; rsv_addr_in = 0;
        #2;
        total_cnt++;
        if (rd_data_out !== 16'h0000) $display("FAIL reset_data: got %h want 0000", rd_data_out);
        else pass_cnt++;
        total_cnt++;
        if (rd_busy_out !== 2'b00) $display("FAIL reset_busy: got %b want 00", rd_busy_out);
        else pass_cnt++;
        total_cnt++;
        if (rsv_conflict_out !== 1'b0) $display("FAIL reset_conflict: got %b want 0", rsv_conflict_out);
        else pass_cnt++;
        step();
        rst_in = 1'b0;
    endtask

    task automatic test_single_write();
        wr_en_in = 1; wr_pair_in = 0; wr_addr_in = 4'd3; wr_data_in = 16'h00AB;
        step();
        wr_en_in = 0;
        set_rd(4'd3, 4'd4);
        total_cnt++;
        if (rd_data_out !== 16'h00AB) $display("FAIL single_wr_rd3_rd4: got %h want 00ab", rd_data_out);
        else pass_cnt++;
        total_cnt++;
        if (rd_busy_out !== 2'b00) $display("FAIL single_wr_busy: got %b want 00", rd_busy_out);
        else pass_cnt++;
    endtask

    task automatic test_pair_write();
        wr_en_in = 1; wr_pair_in = 1; wr_addr_in = 4'd2; wr_data_in = 16'hABCD;
        step();
        wr_en_in = 0;
        set_rd(4'd2, 4'd3);
        total_cnt++;
        if (rd_data_out !== 16'hABCD) $display("FAIL pair_wr_2: got %h want abcd", rd_data_out);
        else pass_cnt++;
        wr_en_in = 1; wr_pair_in = 1; wr_addr_in = 4'd15; wr_data_in = 16'h1234;
        step();
        wr_en_in = 0;
        set_rd(4'd15, 4'd0);
        total_cnt++;
        if (rd_data_out !== 16'h1234) $display("FAIL pair_wr_wrap: got %h want 1234", rd_data_out);
        else pass_cnt++;
    endtask

    task automatic test_forwarding();
        wr_en_in = 1; wr_pair_in = 1; wr_addr_in = 4'd5; wr_data_in = 16'h1122;
        set_rd(4'd5, 4'd6);
        total_cnt++;
        if (rd_data_out !== 16'h1122) $display("FAIL fwd_before_edge: got %h want 1122", rd_data_out);
        else pass_cnt++;
        step();
        wr_en_in = 0;
        #1;
        total_cnt++;
        if (rd_data_out !== 16'h1122) $display("FAIL fwd_stored: got %h want 1122", rd_data_out);
        else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        rsv_en_in = 1; rsv_pair_in = 1; rsv_addr_in = 4'd7;
        step();
        rsv_en_in = 0;
        set_rd(4'd7, 4'd8);
        total_cnt++;
        if (rd_busy_out !== 2'b11) $display("FAIL rsv_pair_busy: got %b want 11", rd_busy_out);
        else pass_cnt++;
        total_cnt++;
        if (rsv_conflict_out !== 1'b0) $display("FAIL rsv_fresh_conflict: got %b want 0", rsv_conflict_out);
        else pass_cnt++;
        wr_en_in = 1; wr_pair_in = 0; wr_addr_in = 4'd7; wr_data_in = 16'h0055;
        #1;
        total_cnt++;
        if (rd_busy_out !== 2'b10) $display("FAIL wr7_fwd_busy: got %b want 10", rd_busy_out);
        else pass_cnt++;
        total_cnt++;
        if (rd_data_out[7:0] !== 8'h55) $display("FAIL wr7_fwd_data: got %h want 55", rd_data_out[7:0]);
        else pass_cnt++;
        step();
        wr_en_in = 0;
        #1;
        total_cnt++;
        if (rd_busy_out !== 2'b10) $display("FAIL wr7_after_busy: got %b want 10", rd_busy_out);
        else pass_cnt++;
        wr_en_in = 1; wr_pair_in = 1; wr_addr_in = 4'd7; wr_data_in = 16'h6677;
        step();
        wr_en_in = 0;
        #1;
        total_cnt++;
        if (rd_busy_out !== 2'b00) $display("FAIL pair7_clear_busy: got %b want 00", rd_busy_out);
        else pass_cnt++;
        total_cnt++;
        if (rd_data_out !== 16'h6677) $display("FAIL pair7_data: got %h want 6677", rd_data_out);
        else pass_cnt++;
    endtask

    task automatic test_conflict();
        set_rd(4'd9, 4'd1);
        rsv_en_in = 1; rsv_pair_in = 0; rsv_addr_in = 4'd9;
        step();
        total_cnt++;
        if (rsv_conflict_out !== 1'b0) $display("FAIL rsv9_first_conflict: got %b want 0", rsv_conflict_out);
        else pass_cnt++;
        step();
        rsv_en_in = 0;
        #1;
        total_cnt++;
        if (rsv_conflict_out !== 1'b1) $display("FAIL rsv9_re_conflict: got %b want 1", rsv_conflict_out);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rsv_conflict_out !== 1'b0) $display("FAIL rsv9_pulse_end: got %b want 0", rsv_conflict_out);
        else pass_cnt++;
        total_cnt++;
        if (rd_busy_out[0] !== 1'b1) $display("FAIL rsv9_still_busy: got %b want 1", rd_busy_out[0]);
        else pass_cnt++;
        // Write and re-reserve 9 together: the write retires the old producer, no conflict.
        wr_en_in = 1; wr_pair_in = 0; wr_addr_in = 4'd9; wr_data_in = 16'h0042;
        rsv_en_in = 1; rsv_pair_in = 0; rsv_addr_in = 4'd9;
        step();
        wr_en_in = 0; rsv_en_in = 0;
        #1;
        total_cnt++;
        if (rsv_conflict_out !== 1'b0) $display("FAIL wr_rsv9_conflict: got %b want 0", rsv_conflict_out);
        else pass_cnt++;
        total_cnt++;
        if (rd_busy_out[0] !== 1'b1) $display("FAIL wr_rsv9_busy: got %b want 1", rd_busy_out[0]);
        else pass_cnt++;
        total_cnt++;
        if (rd_data_out[7:0] !== 8'h42) $display("FAIL wr_rsv9_data: got %h want 42", rd_data_out[7:0]);
        else pass_cnt++;
        // Pair reservation at the top address wraps to register 0.
        rsv_en_in = 1; rsv_pair_in = 1; rsv_addr_in = 4'd15;
        step();
        rsv_en_in = 0;
        set_rd(4'd15, 4'd0);
        total_cnt++;
        if (rd_busy_out !== 2'b11) $display("FAIL rsv_wrap_busy: got %b want 11", rd_busy_out);
        else pass_cnt++;
        total_cnt++;
        if (rsv_conflict_out !== 1'b0) $display("FAIL rsv_wrap_conflict: got %b want 0", rsv_conflict_out);
        else pass_cnt++;
        // Re-reserve the wrapped pair so the conflict pulse is high going into reset.
        rsv_en_in = 1; rsv_pair_in = 1; rsv_addr_in = 4'd15;
        step();
        rsv_en_in = 0;
        #1;
        total_cnt++;
        if (rsv_conflict_out !== 1'b1) $display("FAIL rsv_wrap_re_conflict: got %b want 1", rsv_conflict_out);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        // Registers 15 and 0 hold 34/12 and are busy; a write to 9 is pending.
        wr_en_in = 1; wr_pair_in = 0; wr_addr_in = 4'd9; wr_data_in = 16'h00EE;
        #1;
        rst_in = 1'b1;
        #1;
        total_cnt++;
        if (rd_data_out !== 16'h0000) $display("FAIL mid_rst_data: got %h want 0000", rd_data_out);
        else pass_cnt++;
        total_cnt++;
        if (rd_busy_out !== 2'b00) $display("FAIL mid_rst_busy: got %b want 00", rd_busy_out);
        else pass_cnt++;
        total_cnt++;
        if (rsv_conflict_out !== 1'b0) $display("FAIL mid_rst_conflict: got %b want 0", rsv_conflict_out);
        else pass_cnt++;
        step();
        wr_en_in = 0;
        #1;
        rst_in = 1'b0;
        set_rd(4'd9, 4'd3);
        total_cnt++;
        if (rd_data_out !== 16'h0000) $display("FAIL post_rst_data: got %h want 0000", rd_data_out);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rd_data_out !== 16'h0000) $display("FAIL post_rst_hold: got %h want 0000", rd_data_out);
        else pass_cnt++;
        total_cnt++;
        if (rd_busy_out !== 2'b00) $display("FAIL post_rst_busy: got %b want 00", rd_busy_out);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_pair_write();
        test_forwarding();
        test_scoreboard();
        test_conflict();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
